// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and default widths for the configuration-chain loader.
// Pure declarations: no logic, no latency, no flow control.
package ccff_chain_loader_pkg;

   localparam int WORD_W_DEF = 8;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Control, write-word and readback-word bundle between a programming host and the loader.
// Write and readback words use valid/ready; start/abort are single-cycle pulses.
interface ccff_chain_loader_if
   import ccff_chain_loader_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
);
   logic              start;
   logic              abort;
   logic [CNT_W-1:0]  chain_len;
   logic [WORD_W-1:0] wr_data;
   logic              wr_valid;
   logic              wr_ready;
   logic [WORD_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_ready;
   logic              busy;
   logic              done;

   modport master (
      output start, abort, chain_len, wr_data, wr_valid, rd_ready,
      input  wr_ready, rd_data, rd_valid, busy, done
   );

   modport slave (
      input  start, abort, chain_len, wr_data, wr_valid, rd_ready,
      output wr_ready, rd_data, rd_valid, busy, done
   );
endinterface

// File: rtl/ccff_readback_packer.sv
// Packs tail bits LSB-first into words; capture -> hold transfer is one edge after the word fills.
// Asserts stall when capture is full and the hold word is still unaccepted, so no tail bit is dropped.
module ccff_readback_packer
   import ccff_chain_loader_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   input  logic              clear,
   input  logic              cap_en,
   input  logic              tail_bit,
   input  logic              flush,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              stall,
   output logic              empty
);
   localparam int CCNT_W = $clog2(WORD_W + 1);
   localparam logic [CCNT_W-1:0] CAP_FULL = CCNT_W'(WORD_W);

   logic [WORD_W-1:0] cap_q, cap_d;
   logic [CCNT_W-1:0] cap_cnt_q, cap_cnt_d;
   logic [WORD_W-1:0] hold_q, hold_d;
   logic              hold_vld_q, hold_vld_d;
   logic              cap_full, xfer;

   assign cap_full = (cap_cnt_q == CAP_FULL);
   // A partial word only leaves capture during flush; untouched bits stay zero.
   assign xfer     = !hold_vld_q && (cap_full || (flush && (cap_cnt_q != '0)));
   assign stall    = cap_full && hold_vld_q;
   assign empty    = (cap_cnt_q == '0) && !hold_vld_q;
   assign rd_data  = hold_q;
   assign rd_valid = hold_vld_q;

   always_comb begin
      cap_d      = cap_q;
      cap_cnt_d  = cap_cnt_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      if (clear) begin
         cap_d      = '0;
         cap_cnt_d  = '0;
         hold_d     = '0;
         hold_vld_d = 1'b0;
      end else begin
         if (hold_vld_q && rd_ready) begin
            hold_vld_d = 1'b0;
         end
         if (xfer) begin
            hold_d     = cap_q;
            hold_vld_d = 1'b1;
            cap_d      = '0;
            cap_cnt_d  = '0;
         end
         if (cap_en) begin
            cap_d     = cap_d | (WORD_W'(tail_bit) << cap_cnt_d);
            cap_cnt_d = cap_cnt_d + CCNT_W'(1);
         end
      end
   end

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         cap_q      <= '0;
         cap_cnt_q  <= '0;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
      end else begin
         cap_q      <= cap_d;
         cap_cnt_q  <= cap_cnt_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
      end
   end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serializes bitstream words onto ccff_head and returns the displaced tail bits as readback words.
// Peak one bit per cycle with one bubble per word; shifting stalls while a readback word waits on rd_ready.
module ccff_chain_loader
   import ccff_chain_loader_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              prog_clk,
   input  logic              pReset_n,
   ccff_chain_loader_if.slave bus,
   output logic              config_enable,
   output logic              ccff_head,
   input  logic              ccff_tail
);
   localparam int BIDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(WORD_W - 1);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [WORD_W-1:0] wbuf_q, wbuf_d;
   logic              wbuf_vld_q, wbuf_vld_d;
   logic [BIDX_W-1:0] bidx_q, bidx_d;
   logic              done_q, done_d;
   logic              shift, stall, pk_empty, wr_rdy, wr_fire;

   assign shift         = (state_q == SHIFT) && wbuf_vld_q && !stall;
   assign config_enable = shift;
   assign ccff_head     = shift & wbuf_q[bidx_q];
   assign wr_rdy        = (state_q == SHIFT) && !wbuf_vld_q;
   assign wr_fire       = bus.wr_valid && wr_rdy;
   assign bus.wr_ready  = wr_rdy;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;

   ccff_readback_packer #(.WORD_W(WORD_W)) u_packer (
      .prog_clk (prog_clk),
      .pReset_n (pReset_n),
      .clear    (bus.abort),
      .cap_en   (shift),
      .tail_bit (ccff_tail),
      .flush    (state_q == FLUSH),
      .rd_data  (bus.rd_data),
      .rd_valid (bus.rd_valid),
      .rd_ready (bus.rd_ready),
      .stall    (stall),
      .empty    (pk_empty)
   );

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      wbuf_d     = wbuf_q;
      wbuf_vld_d = wbuf_vld_q;
      bidx_d     = bidx_q;
      done_d     = 1'b0;
      if (bus.abort) begin
         state_d    = IDLE;
         rem_d      = '0;
         wbuf_d     = '0;
         wbuf_vld_d = 1'b0;
         bidx_d     = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (bus.chain_len != '0) begin
                     state_d = SHIFT;
                     rem_d   = bus.chain_len;
                  end else begin
                     state_d = DONE;
                  end
               end
            end
            SHIFT: begin
               if (wr_fire) begin
                  wbuf_d     = bus.wr_data;
                  wbuf_vld_d = 1'b1;
                  bidx_d     = '0;
               end
               if (shift) begin
                  rem_d  = rem_q - CNT_W'(1);
                  bidx_d = bidx_q + BIDX_W'(1);
                  // Last chain bit also drops whatever remains of a partial word.
                  if ((bidx_q == BIDX_LAST) || (rem_q == CNT_W'(1))) begin
                     wbuf_vld_d = 1'b0;
                     bidx_d     = '0;
                  end
                  if (rem_q == CNT_W'(1)) begin
                     state_d = FLUSH;
                  end
               end
            end
            FLUSH: begin
               if (pk_empty) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         state_q    <= IDLE;
         rem_q      <= '0;
         wbuf_q     <= '0;
         wbuf_vld_q <= 1'b0;
         bidx_q     <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         wbuf_q     <= wbuf_d;
         wbuf_vld_q <= wbuf_vld_d;
         bidx_q     <= bidx_d;
         done_q     <= done_d;
      end
   end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a shift-register chain model on head/tail and a readback scoreboard.
module tb_ccff_chain_loader;
   import ccff_chain_loader_pkg::*;

   localparam int WORD_W = WORD_W_DEF;
   localparam int CNT_W  = CNT_W_DEF;

   logic prog_clk = 1'b0;
   logic pReset_n = 1'b0;
   logic config_enable, ccff_head, ccff_tail;

   ccff_chain_loader_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

   ccff_chain_loader #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .prog_clk      (prog_clk),
      .pReset_n      (pReset_n),
      .bus           (bus),
      .config_enable (config_enable),
      .ccff_head     (ccff_head),
      .ccff_tail     (ccff_tail)
   );

   always #5 prog_clk = ~prog_clk;

   int checks = 0;
   int errors = 0;
   logic [31:0] chain_sr    = '0;
   logic [31:0] preload_val = '0;
   int chain_len_m = 1;
   int preload_seq = 0;
   int seen_seq    = 0;
   int cfg_cnt     = 0;
   int done_cnt    = 0;
   bit head_q[$];
   logic [WORD_W-1:0] exp_q[$];
   logic [WORD_W-1:0] exp_w;

   assign ccff_tail = chain_sr[0];

   // Chain model, shift/done counters and readback scoreboard.
   always @(posedge prog_clk) begin
      if (preload_seq != seen_seq) begin
         chain_sr <= preload_val;
         seen_seq <= preload_seq;
      end else if (config_enable) begin
         chain_sr <= (chain_sr >> 1) | ({31'b0, ccff_head} << (chain_len_m - 1));
      end
      if (config_enable) begin
         cfg_cnt <= cfg_cnt + 1;
         head_q.push_back(ccff_head);
      end
      if (bus.done) done_cnt <= done_cnt + 1;
      if (bus.rd_valid && bus.rd_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rd_word unexpected: got %h, required no word", bus.rd_data);
         end else begin
            exp_w = exp_q.pop_front();
            if (bus.rd_data !== exp_w) begin
               errors++;
               $display("FAIL rd_word: got %h, required %h", bus.rd_data, exp_w);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge prog_clk);
      #1;
   endtask

   task automatic preload(input logic [31:0] val, input int len, input bit push_exp);
      logic [31:0] masked;
      masked = (len >= 32) ? val : (val & ((32'h1 << len) - 32'h1));
      preload_val = masked;
      chain_len_m = len;
      preload_seq++;
      if (push_exp) begin
         for (int i = 0; i < (len + WORD_W - 1) / WORD_W; i++)
            exp_q.push_back(WORD_W'(masked >> (i * WORD_W)));
      end
      cyc(1);
   endtask

   task automatic start_load(input int len);
      bus.chain_len = CNT_W'(len);
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
   endtask

   task automatic feed_word(input logic [WORD_W-1:0] d, output bit ok);
      ok = 1'b0;
      bus.wr_data  = d;
      bus.wr_valid = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if (bus.wr_ready) begin
            cyc(1);
            ok = 1'b1;
            break;
         end
         cyc(1);
      end
      bus.wr_valid = 1'b0;
   endtask

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
         cyc(1);
      end
   endtask

   task automatic test_reset;
      checks++;
      if ({config_enable, ccff_head, bus.wr_ready, bus.rd_valid, bus.busy, bus.done} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b, required 000000",
                  {config_enable, ccff_head, bus.wr_ready, bus.rd_valid, bus.busy, bus.done});
      end
      checks++;
      if (bus.rd_data !== '0) begin
         errors++;
         $display("FAIL reset_rd_data: got %h, required 00", bus.rd_data);
      end
   endtask

   task automatic test_basic;
      int bc, bd, hb;
      bit ok1, ok2, seen;
      logic [31:0] hv;
      bc = cfg_cnt; bd = done_cnt; hb = head_q.size();
      preload(32'h0ABC, 13, 1'b1);
      start_load(13);
      feed_word(8'hA5, ok1);
      feed_word(8'h1F, ok2);
      wait_done(seen);
      checks++;
      if (!(ok1 && ok2 && seen)) begin
         errors++;
         $display("FAIL basic_progress: got feed=%0d%0d done=%0d, required 111", ok1, ok2, seen);
      end
      cyc(1);
      checks++;
      if (bus.done !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_width: got done=%b one cycle later, required 0", bus.done);
      end
      cyc(1);
      checks++;
      if (cfg_cnt - bc != 13) begin
         errors++;
         $display("FAIL basic_shift_count: got %0d, required 13", cfg_cnt - bc);
      end
      hv = '0;
      for (int i = 0; i < head_q.size() - hb && i < 32; i++) hv[i] = head_q[hb + i];
      checks++;
      if (hv !== 32'h1FA5) begin
         errors++;
         $display("FAIL basic_head_bits: got %h, required 00001fa5", hv);
      end
      checks++;
      if (chain_sr[12:0] !== 13'h1FA5) begin
         errors++;
         $display("FAIL basic_chain: got %h, required 1fa5", chain_sr[12:0]);
      end
      checks++;
      if (exp_q.size() != 0 || done_cnt - bd != 1) begin
         errors++;
         $display("FAIL basic_readback_done: got pending=%0d done=%0d, required 0 and 1",
                  exp_q.size(), done_cnt - bd);
      end
   endtask

   task automatic test_zero_len;
      int bc;
      bc = cfg_cnt;
      bus.chain_len = '0;
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL zero_len_c1: got done=%b busy=%b, required 0 1", bus.done, bus.busy);
      end
      cyc(1);
      checks++;
      if (bus.done !== 1'b1) begin
         errors++;
         $display("FAIL zero_len_c2: got done=%b, required 1", bus.done);
      end
      cyc(1);
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || cfg_cnt != bc) begin
         errors++;
         $display("FAIL zero_len_after: got done=%b busy=%b shifts=%0d, required 0 0 0",
                  bus.done, bus.busy, cfg_cnt - bc);
      end
   endtask

   task automatic test_backpressure;
      int bc, bd;
      bit ok1, ok2, ok3, seen;
      bc = cfg_cnt; bd = done_cnt;
      bus.rd_ready = 1'b0;
      preload(32'h3C5A96, 24, 1'b1);
      start_load(24);
      feed_word(8'h11, ok1);
      feed_word(8'h22, ok2);
      feed_word(8'h33, ok3);
      cyc(10);
      checks++;
      if (!(ok1 && ok2 && ok3) || cfg_cnt - bc != 16 || config_enable !== 1'b0) begin
         errors++;
         $display("FAIL bp_stall: got feeds=%0d%0d%0d shifts=%0d cfg_en=%b, required 111 16 0",
                  ok1, ok2, ok3, cfg_cnt - bc, config_enable);
      end
      checks++;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== exp_q[0]) begin
         errors++;
         $display("FAIL bp_hold: got valid=%b data=%h, required 1 %h", bus.rd_valid, bus.rd_data, exp_q[0]);
      end
      bus.rd_ready = 1'b1;
      wait_done(seen);
      cyc(2);
      checks++;
      if (!seen || cfg_cnt - bc != 24 || chain_sr[23:0] !== 24'h332211) begin
         errors++;
         $display("FAIL bp_resume: got done=%0d shifts=%0d chain=%h, required 1 24 332211",
                  seen, cfg_cnt - bc, chain_sr[23:0]);
      end
      checks++;
      if (exp_q.size() != 0 || done_cnt - bd != 1) begin
         errors++;
         $display("FAIL bp_readback: got pending=%0d done=%0d, required 0 1", exp_q.size(), done_cnt - bd);
      end
   endtask

   task automatic test_wr_gap;
      int bc;
      bit ok1, ok2, seen, rdy;
      bc = cfg_cnt;
      preload(32'h0ABC, 13, 1'b1);
      start_load(13);
      feed_word(8'hA5, ok1);
      rdy = 1'b0;
      for (int i = 0; i < 50 && !rdy; i++) begin
         rdy = bus.wr_ready;
         if (!rdy) cyc(1);
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (config_enable !== 1'b0) begin
            errors++;
            $display("FAIL gap_cfg_en cycle %0d: got %b, required 0", i, config_enable);
         end
         cyc(1);
      end
      feed_word(8'h1F, ok2);
      wait_done(seen);
      cyc(2);
      checks++;
      if (!(ok1 && ok2 && seen && rdy) || cfg_cnt - bc != 13 || chain_sr[12:0] !== 13'h1FA5 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL gap_result: got ok=%0d%0d%0d%0d shifts=%0d chain=%h pending=%0d, required 1111 13 1fa5 0",
                  ok1, ok2, seen, rdy, cfg_cnt - bc, chain_sr[12:0], exp_q.size());
      end
   endtask

   task automatic test_abort;
      int bc, bd;
      bit ok1, ok2, seen;
      bc = cfg_cnt; bd = done_cnt;
      preload(32'hFFFF, 16, 1'b0);
      start_load(16);
      feed_word(8'h5A, ok1);
      for (int i = 0; i < 50 && cfg_cnt - bc < 5; i++) cyc(1);
      bus.abort = 1'b1;
      cyc(1);
      bus.abort = 1'b0;
      checks++;
      if (config_enable !== 1'b0 || bus.busy !== 1'b0 || !ok1) begin
         errors++;
         $display("FAIL abort_now: got cfg_en=%b busy=%b feed=%0d, required 0 0 1", config_enable, bus.busy, ok1);
      end
      cyc(5);
      checks++;
      if (done_cnt != bd || bus.rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL abort_no_done: got done=%0d rd_valid=%b, required 0 0", done_cnt - bd, bus.rd_valid);
      end
      bc = cfg_cnt;
      preload(32'h96, 8, 1'b1);
      start_load(8);
      feed_word(8'hC3, ok2);
      wait_done(seen);
      cyc(2);
      checks++;
      if (!(ok2 && seen) || cfg_cnt - bc != 8 || chain_sr[7:0] !== 8'hC3 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL abort_reload: got ok=%0d%0d shifts=%0d chain=%h pending=%0d, required 11 8 c3 0",
                  ok2, seen, cfg_cnt - bc, chain_sr[7:0], exp_q.size());
      end
   endtask

   task automatic test_reset_mid;
      int bc, bd;
      bit ok1, ok2, ok3, seen;
      bc = cfg_cnt;
      preload(32'h1234, 16, 1'b1);
      start_load(16);
      feed_word(8'hAA, ok1);
      feed_word(8'h55, ok2);
      for (int i = 0; i < 50 && cfg_cnt - bc < 11; i++) cyc(1);
      #2 pReset_n = 1'b0;
      #1;
      checks++;
      if ({config_enable, ccff_head, bus.wr_ready, bus.rd_valid, bus.busy, bus.done} !== 6'b0 || bus.rd_data !== '0) begin
         errors++;
         $display("FAIL rst_mid_outputs: got %b rd_data=%h, required 000000 00",
                  {config_enable, ccff_head, bus.wr_ready, bus.rd_valid, bus.busy, bus.done}, bus.rd_data);
      end
      exp_q.delete();
      cyc(3);
      checks++;
      if (cfg_cnt - bc != 11 || !(ok1 && ok2)) begin
         errors++;
         $display("FAIL rst_mid_frozen: got shifts=%0d feeds=%0d%0d, required 11 11", cfg_cnt - bc, ok1, ok2);
      end
      pReset_n = 1'b1;
      cyc(2);
      bc = cfg_cnt; bd = done_cnt;
      preload(32'h69, 8, 1'b1);
      start_load(8);
      feed_word(8'hE7, ok3);
      wait_done(seen);
      cyc(2);
      checks++;
      if (!(ok3 && seen) || cfg_cnt - bc != 8 || chain_sr[7:0] !== 8'hE7 || exp_q.size() != 0 || done_cnt - bd != 1) begin
         errors++;
         $display("FAIL rst_mid_reload: got ok=%0d%0d shifts=%0d chain=%h pending=%0d done=%0d, required 11 8 e7 0 1",
                  ok3, seen, cfg_cnt - bc, chain_sr[7:0], exp_q.size(), done_cnt - bd);
      end
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.abort     = 1'b0;
      bus.chain_len = '0;
      bus.wr_data   = '0;
      bus.wr_valid  = 1'b0;
      bus.rd_ready  = 1'b1;
      repeat (3) @(posedge prog_clk);
      #1;
      test_reset();
      pReset_n = 1'b1;
      cyc(2);
      test_basic();
      test_zero_len();
      test_backpressure();
      test_wr_gap();
      test_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
